// File: rtl/serial_adder_arbiter.sv
// serial_adder_arbiter: shares one serial adder between two requesters.
// Ports: clk, rst (sync, active-high); req0/a0/b0, req1/a1/b1 requests;
//   ack0/ack1 one-cycle completion pulses; result {carry, sum}; busy;
//   adder_load_a/b, adder_en, adder_data_a/b drive the serial adder;
//   adder_sum/adder_cout come back from it.
// Option: define SERIAL_ARB_FIXED_PRIO_EN for fixed priority (req0 wins);
//   otherwise arbitration is round-robin.
module serial_adder_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH:0]   result,
    output logic             busy,
    output logic             adder_load_a,
    output logic             adder_load_b,
    output logic             adder_en,
    output logic [WIDTH-1:0] adder_data_a,
    output logic [WIDTH-1:0] adder_data_b,
    input  logic             adder_sum,
    input  logic             adder_cout
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_sr;
    logic             grant_id;
    logic             pick1;

`ifdef SERIAL_ARB_FIXED_PRIO_EN
    // req1 only wins when req0 is absent
    assign pick1 = req1 & ~req0;
`else
    // prio=1 means req1 is favoured on a tie
    logic prio;
    assign pick1 = req1 & (~req0 | prio);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            sum_sr       <= '0;
            grant_id     <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            result       <= '0;
            busy         <= 1'b0;
            adder_load_a <= 1'b0;
            adder_load_b <= 1'b0;
            adder_en     <= 1'b0;
            adder_data_a <= '0;
            adder_data_b <= '0;
`ifndef SERIAL_ARB_FIXED_PRIO_EN
            prio         <= 1'b0;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (busy) begin
                        // ack cycle: finish the handshake, arbitrate next cycle
                        busy <= 1'b0;
                    end else if (req0 | req1) begin
                        grant_id     <= pick1;
                        adder_data_a <= pick1 ? a1 : a0;
                        adder_data_b <= pick1 ? b1 : b0;
                        busy         <= 1'b1;
                        adder_load_a <= 1'b1;
                        adder_load_b <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    adder_load_a <= 1'b0;
                    adder_load_b <= 1'b0;
                    adder_en     <= 1'b1;
                    cnt          <= '0;
                    sum_sr       <= '0;
                    state        <= SHIFT;
                end
                SHIFT: begin
                    // LSB arrives first, so shift in from the top
                    sum_sr <= {adder_sum, sum_sr[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        adder_en <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // carry register settles the cycle after the last enable
                    result <= {adder_cout, sum_sr};
                    ack0   <= ~grant_id;
                    ack1   <= grant_id;
`ifndef SERIAL_ARB_FIXED_PRIO_EN
                    prio   <= ~grant_id;
`endif
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_arbiter.sv
// tb_serial_adder_arbiter: directed bench for serial_adder_arbiter.
// Includes a behavioural serial full adder driven by the DUT strobes.
module tb_serial_adder_arbiter;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
`ifdef SERIAL_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0 = 1'b0;
    logic [WIDTH-1:0] a0 = '0;
    logic [WIDTH-1:0] b0 = '0;
    logic             req1 = 1'b0;
    logic [WIDTH-1:0] a1 = '0;
    logic [WIDTH-1:0] b1 = '0;
    logic             ack0;
    logic             ack1;
    logic [WIDTH:0]   result;
    logic             busy;
    logic             adder_load_a;
    logic             adder_load_b;
    logic             adder_en;
    logic [WIDTH-1:0] adder_data_a;
    logic [WIDTH-1:0] adder_data_b;
    logic             adder_sum;
    logic             adder_cout;

    int checks = 0;
    int errors = 0;

    serial_adder_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .a0           (a0),
        .b0           (b0),
        .req1         (req1),
        .a1           (a1),
        .b1           (b1),
        .ack0         (ack0),
        .ack1         (ack1),
        .result       (result),
        .busy         (busy),
        .adder_load_a (adder_load_a),
        .adder_load_b (adder_load_b),
        .adder_en     (adder_en),
        .adder_data_a (adder_data_a),
        .adder_data_b (adder_data_b),
        .adder_sum    (adder_sum),
        .adder_cout   (adder_cout)
    );

    always #5 clk = ~clk;

    // serial full adder: parallel load clears carry, enable shifts LSB-first
    logic [WIDTH-1:0] ra = '0;
    logic [WIDTH-1:0] rb = '0;
    logic             carry = 1'b0;
    assign adder_sum  = ra[0] ^ rb[0] ^ carry;
    assign adder_cout = carry;

    always @(posedge clk) begin
        if (adder_load_a) ra <= adder_data_a;
        if (adder_load_b) rb <= adder_data_b;
        if (adder_load_a | adder_load_b) begin
            carry <= 1'b0;
        end else if (adder_en) begin
            carry <= (ra[0] & rb[0]) | (carry & (ra[0] ^ rb[0]));
            ra    <= ra >> 1;
            rb    <= rb >> 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // advance until an ack is visible; n = edges passed, ens = enable cycles
    task automatic wait_ack(output int n, output int ens);
        bit seen;
        n    = 0;
        ens  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            n++;
            if (adder_en) ens++;
            check("load_en_excl", 32'(adder_load_a & adder_en), 32'd0);
            if (ack0 | ack1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL ack_timeout: observed no ack expected ack");
        end
    endtask

    int n;
    int ens;

    initial begin
        step();
        step();
        rst = 1'b0;
        check("rst_ack", 32'({ack0, ack1}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobes", 32'({adder_load_a, adder_load_b, adder_en}), 32'd0);
        check("rst_data", 32'({adder_data_a, adder_data_b}), 32'd0);
        check("rst_result", 32'(result), 32'd0);

        // single request 5+3
        a0 = 8'd5; b0 = 8'd3; req0 = 1'b1;
        step();
        check("s_busy", 32'(busy), 32'd1);
        check("s_load", 32'({adder_load_a, adder_load_b, adder_en}), 32'b110);
        check("s_data_a", 32'(adder_data_a), 32'd5);
        check("s_data_b", 32'(adder_data_b), 32'd3);
        wait_ack(n, ens);
        check("s_latency", 32'(n + 1), 32'(WIDTH + 3));
        check("s_en_cycles", 32'(ens), 32'(WIDTH));
        check("s_ack", 32'({ack0, ack1}), 32'b10);
        check("s_result", 32'(result), 32'd8);
        check("s_busy_ack", 32'(busy), 32'd1);
        req0 = 1'b0;
        step();
        check("s_ack_pulse", 32'({ack0, ack1}), 32'd0);
        check("s_busy_drop", 32'(busy), 32'd0);
        check("s_result_hold", 32'(result), 32'd8);

        // carry: 200+100 via req1, then 255+255 via req0
        a1 = 8'd200; b1 = 8'd100; req1 = 1'b1;
        wait_ack(n, ens);
        check("c1_ack", 32'({ack0, ack1}), 32'b01);
        check("c1_result", 32'(result), 32'd300);
        req1 = 1'b0;
        step();
        a0 = 8'd255; b0 = 8'd255; req0 = 1'b1;
        wait_ack(n, ens);
        check("c2_ack", 32'({ack0, ack1}), 32'b10);
        check("c2_result", 32'(result), 32'd510);
        req0 = 1'b0;
        step();

        // simultaneous requests from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        a0 = 8'd7; b0 = 8'd1; a1 = 8'd10; b1 = 8'd20;
        req0 = 1'b1; req1 = 1'b1;
        wait_ack(n, ens);
        check("rr1_ack", 32'({ack0, ack1}), 32'b10);
        check("rr1_result", 32'(result), 32'd8);
        req0 = 1'b0;
        step();
        req0 = 1'b1;
        wait_ack(n, ens);
        check("rr2_ack", 32'({ack0, ack1}), FIXED ? 32'b10 : 32'b01);
        check("rr2_result", 32'(result), FIXED ? 32'd8 : 32'd30);
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // back-to-back: req1 arrives while req0 is served
        a0 = 8'd1; b0 = 8'd2; req0 = 1'b1;
        step();
        step();
        a1 = 8'd3; b1 = 8'd4; req1 = 1'b1;
        wait_ack(n, ens);
        check("bb_ack0", 32'({ack0, ack1}), 32'b10);
        check("bb_result0", 32'(result), 32'd3);
        req0 = 1'b0;
        step();
        check("bb_idle_load", 32'(adder_load_a), 32'd0);
        step();
        check("bb_load", 32'({adder_load_a, adder_load_b}), 32'b11);
        check("bb_data_a", 32'(adder_data_a), 32'd3);
        wait_ack(n, ens);
        check("bb_ack1", 32'({ack0, ack1}), 32'b01);
        check("bb_result1", 32'(result), 32'd7);
        req1 = 1'b0;
        step();

        // reset on the 4th enable cycle
        a0 = 8'd100; b0 = 8'd50; req0 = 1'b1;
        ens = 0;
        for (int i = 0; i < 20 && ens < 4; i++) begin
            step();
            if (adder_en) ens++;
        end
        check("mr_reached", 32'(ens), 32'd4);
        rst = 1'b1; req0 = 1'b0;
        step();
        rst = 1'b0;
        check("mr_ack", 32'({ack0, ack1}), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_strobes", 32'({adder_load_a, adder_load_b, adder_en}), 32'd0);
        check("mr_data", 32'({adder_data_a, adder_data_b}), 32'd0);
        check("mr_result", 32'(result), 32'd0);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (ack0 | ack1) n++;
        end
        check("mr_no_ack", 32'(n), 32'd0);
        a0 = 8'd12; b0 = 8'd34; req0 = 1'b1;
        wait_ack(n, ens);
        check("mr_fresh_ack", 32'({ack0, ack1}), 32'b10);
        check("mr_fresh_result", 32'(result), 32'd46);
        req0 = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
